mode_controller: RTL and testbench
==================================

Name: mode_controller

Overview:
- Sequencing front-end for the DE10-Lite ALU datapath (arithmetic / logical / comparison / magic units plus the hex/LED muxes).
- Replaces the combinational key-to-mode mapping with a registered controller:
  - debounces and edge-detects both push-buttons;
  - cycles the 2-bit MODE select;
  - operand/operation registers either track the switches live or freeze a snapshot.
- Outputs feed the datapath unit selects and operand buses directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of the debounce counters.
- SCAN_CYCLES, 25000000, auto-repeat period in cycles (used only with AUTO_SCAN_EN).

Ports:
- CLK  input  1  system clock (50 MHz board clock).
- RST  input  1  asynchronous, active-high reset.
- KEY  input  2  raw push-buttons, active-low, asynchronous to CLK. KEY[0] = mode advance, KEY[1] = hold toggle.
- SW  input  10  raw slide switches. SW[3:0] = X, SW[7:4] = Y, SW[9:8] = operation.
- MODE  output  2  datapath select. 0 = arithmetic, 1 = logical, 2 = comparison, 3 = magic.
- X  output  4  operand X to the datapath.
- Y  output  4  operand Y to the datapath.
- OPERATION  output  2  per-unit operation select.
- HOLD  output  1  1 = operands frozen; intended for an LED.
- MODE_CHANGE  output  1  one-cycle pulse on every MODE update.

Behaviour:
- Reset values (async, while RST=1):
  - MODE=0, X=0, Y=0, OPERATION=0, HOLD=0, MODE_CHANGE=0.
  - Synchronizer flops=1; debounced levels=1 (released); debounce counters=0.
  - Auto-repeat counter=0.
- Synchronizer: each KEY bit passes through 2 flops. SW is also double-registered before use.
- Debounce, per key:
  - Counter increments every cycle that the synced level differs from the debounced level.
  - Counter clears on any cycle where the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with levels still different, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Press event: debounced level goes 1->0. A release (0->1) produces no event.
- Latency: MODE and HOLD update exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples KEY low, provided KEY stays low throughout.
- State machine: two states.
  - LIVE (HOLD=0): X, Y and OPERATION load from synced SW every cycle, so they lag SW by 3 cycles.
  - FROZEN (HOLD=1): X, Y and OPERATION keep their values.
  - KEY[1] press toggles LIVE <-> FROZEN.
  - Entering FROZEN captures the synced SW value present in the same cycle as the press event.
- MODE sequencing:
  - KEY[0] press sets MODE <= MODE+1 mod 4, wrapping 3 -> 0.
  - MODE_CHANGE = 1 for exactly the cycle after the update.
  - MODE advances identically in both LIVE and FROZEN.
- Simultaneous events: both press events in the same cycle cause the MODE advance and the HOLD toggle together, in one cycle.
- Holding a key: a held key generates exactly one event. A new event requires a debounced release, then a new debounced press.
- Reset mid-operation: all state returns to reset values immediately. A key still held when RST deasserts does not generate an event until it is released and pressed again.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MODE_CONTROLLER_AUTO_SCAN_EN.
- Defined:
  - While KEY[0] stays debounced-low, an auto-repeat counter runs from the press event.
  - Every SCAN_CYCLES cycles it issues an additional MODE advance and MODE_CHANGE pulse.
  - The counter clears on release or reset.
- Undefined:
  - The counter and its logic are absent.
  - A held KEY[0] yields exactly one advance.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_CYCLES=16):
- Reset check: assert RST for 3 cycles with KEY=2'b11 and SW=10'h3FF -> all outputs 0. After release, X=4'hF, Y=4'hF and OPERATION=2'b11 from the 4th cycle on (LIVE tracking).
- Mode wrap: four clean KEY[0] presses (low 10 cycles, high 10 cycles) -> MODE steps 1, 2, 3, 0. Each update lands exactly 7 edges after KEY low, with one MODE_CHANGE pulse per press.
- Glitch rejection: KEY[0] low for 3 cycles, then high -> MODE unchanged, no MODE_CHANGE pulse.
- Hold: SW=10'h2A5, press KEY[1] -> HOLD=1, X=5, Y=A, OPERATION=2. Then change SW to 10'h000 -> outputs unchanged. Press KEY[1] again -> HOLD=0 and outputs become 0 within 3 cycles.
- Simultaneous: KEY=2'b00 falling on the same edge with MODE=1 and HOLD=0 -> in one cycle MODE=2 and HOLD=1.
- Auto-scan (macro defined): hold KEY[0] low for 60 cycles -> MODE advances at the press and then every 16 cycles, for 4 advances total. With the macro undefined -> exactly 1 advance.

Source files
------------

// File: rtl/mode_controller.sv
// mode_controller -- registered sequencing front-end for the DE10-Lite ALU.
//
// Debounces and edge-detects the two push-buttons. Steps the 2-bit MODE
// select on KEY[0]. Toggles between tracking the switches live and holding
// a frozen snapshot on KEY[1].
//
// Optional feature macro: MODE_CONTROLLER_AUTO_SCAN_EN. When it is defined,
// a held KEY[0] auto-repeats the MODE advance every SCAN_CYCLES cycles.
//
// Ports:
//   CLK         in   1   system clock
//   RST         in   1   asynchronous active-high reset
//   KEY         in   2   raw push-buttons, active-low (0 = advance, 1 = hold)
//   SW          in  10   raw switches: [3:0]=X, [7:4]=Y, [9:8]=operation
//   MODE        out  2   datapath unit select
//   X, Y        out  4   operands
//   OPERATION   out  2   per-unit operation select
//   HOLD        out  1   1 = operands frozen
//   MODE_CHANGE out  1   one-cycle pulse accompanying each MODE update

// Per-key synchronizer + debouncer + press detector.
//   key_i   : raw key, active-low, asynchronous
//   press_o : one-cycle press event (debounced 1->0), registered-source
//   level_o : debounced level (1 = released)
module mode_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_i,
    output logic press_o,
    output logic level_o
);
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [1:0]       valid_q;
    logic             armed_q, armed_d;
    logic             synced;

    assign synced = sync_q[1];

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (synced != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A key held through reset must not produce an event. Arming happens
    // only once the synchronizer shows a real released level, or after a
    // debounced release.
    always_comb begin
        armed_d = armed_q;
        if (valid_q[1] && synced && deb_q) armed_d = 1'b1;
        if (!deb_prev_q && deb_q)          armed_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            valid_q    <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_i};
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            valid_q    <= {valid_q[0], 1'b1};
            armed_q    <= armed_d;
        end
    end

    // The press is detected one cycle after the debounced flip. This places
    // the MODE/HOLD update DEBOUNCE_CYCLES+3 edges after KEY is first
    // sampled low.
    assign press_o = armed_q & deb_prev_q & ~deb_q;
    assign level_o = deb_q;
endmodule

module mode_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SCAN_CYCLES     = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [1:0] MODE,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [1:0] OPERATION,
    output logic       HOLD,
    output logic       MODE_CHANGE
);
    typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} state_t;

    // Parameter sanity: an illegal configuration elaborates to nothing useful.
    if (DEBOUNCE_CYCLES < 2 || SCAN_CYCLES < 1) begin : g_bad_params
    end

    logic [1:0] key_press;
    logic [1:0] key_level;
    logic       unused_level;

    for (genvar i = 0; i < 2; i++) begin : g_key
        mode_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .CLK    (CLK),
            .RST    (RST),
            .key_i  (KEY[i]),
            .press_o(key_press[i]),
            .level_o(key_level[i])
        );
    end

    logic [9:0] sw1_q, sw2_q;
    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [1:0] op_q, op_d;
    logic       mc_q, mc_d;
    logic       advance;

`ifdef MODE_CONTROLLER_AUTO_SCAN_EN
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              scan_run_q, scan_run_d;
    logic              scan_tick;

    assign unused_level = key_level[1];

    // Runs only after a real press, so a key held through reset never scans.
    assign scan_tick = scan_run_q && !key_press[0] && !key_level[0] &&
                       (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1));

    always_comb begin
        scan_run_d = !key_level[0] && (key_press[0] || scan_run_q);
        scan_cnt_d = '0;
        if (scan_run_q && !key_press[0] && !key_level[0] && !scan_tick)
            scan_cnt_d = scan_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_cnt_q <= '0;
            scan_run_q <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_run_q <= scan_run_d;
        end
    end

    assign advance = key_press[0] | scan_tick;
`else
    assign unused_level = ^key_level;
    assign advance      = key_press[0];
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        mc_d    = 1'b0;

        if (advance) begin
            mode_d = mode_q + 2'd1;
            mc_d   = 1'b1;
        end

        // LIVE loads every cycle, including the one that enters FROZEN,
        // so the snapshot is the synced SW from the press cycle.
        case (state_q)
            LIVE: begin
                x_d  = sw2_q[3:0];
                y_d  = sw2_q[7:4];
                op_d = sw2_q[9:8];
                if (key_press[1]) state_d = FROZEN;
            end
            FROZEN: begin
                if (key_press[1]) state_d = LIVE;
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw1_q   <= '0;
            sw2_q   <= '0;
            state_q <= LIVE;
            mode_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            mc_q    <= 1'b0;
        end else begin
            sw1_q   <= SW;
            sw2_q   <= sw1_q;
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            mc_q    <= mc_d;
        end
    end

    assign MODE        = mode_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign OPERATION   = op_q;
    assign HOLD        = (state_q == FROZEN);
    assign MODE_CHANGE = mc_q;
endmodule

// File: tb/tb_mode_controller.sv
module tb_mode_controller;
    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [1:0] MODE;
    logic [3:0] X, Y;
    logic [1:0] OPERATION;
    logic       HOLD, MODE_CHANGE;

    int n_tests = 0;
    int n_fail  = 0;

    mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20),
        .SCAN_CYCLES    (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY        (KEY),
        .SW         (SW),
        .MODE       (MODE),
        .X          (X),
        .Y          (Y),
        .OPERATION  (OPERATION),
        .HOLD       (HOLD),
        .MODE_CHANGE(MODE_CHANGE)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled on the falling edge; each step
    // spans exactly one rising edge.
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts MODE_CHANGE pulses seen over n steps.
    task automatic count_mc(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            step(1);
            if (MODE_CHANGE === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [1:0] exp_mode;

        // Reset check
        RST = 1'b1; KEY = 2'b11; SW = 10'h3FF;
        step(3);
        check("rst_mode", MODE, 0);
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_op", OPERATION, 0);
        check("rst_hold", HOLD, 0);
        check("rst_mc", MODE_CHANGE, 0);
        RST = 1'b0;
        step(2);
        check("live_x_early", X, 0);
        step(1);
        check("live_x", X, 4'hF);
        check("live_y", Y, 4'hF);
        check("live_op", OPERATION, 2'b11);
        step(5);

        // Mode wrap: update lands exactly 7 edges after KEY goes low
        exp_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            KEY[0] = 1'b0;
            step(6);
            check("wrap_pre_mode", MODE, exp_mode);
            check("wrap_pre_mc", MODE_CHANGE, 0);
            step(1);
            exp_mode = exp_mode + 2'd1;
            check("wrap_mode", MODE, exp_mode);
            check("wrap_mc", MODE_CHANGE, 1);
            step(1);
            check("wrap_mc_drop", MODE_CHANGE, 0);
            step(2);
            KEY[0] = 1'b1;
            step(10);
        end
        check("wrap_final", MODE, 0);

        // Glitch rejection: 3 cycles low is one short of the threshold
        KEY[0] = 1'b0;
        step(3);
        KEY[0] = 1'b1;
        count_mc(15, pulses);
        check("glitch_mc", pulses, 0);
        check("glitch_mode", MODE, 0);

        // Hold snapshot
        SW = 10'h2A5;
        step(4);
        KEY[1] = 1'b0;
        step(6);
        check("hold_pre", HOLD, 0);
        step(1);
        check("hold_on", HOLD, 1);
        check("hold_x", X, 4'h5);
        check("hold_y", Y, 4'hA);
        check("hold_op", OPERATION, 2'd2);
        step(3);
        KEY[1] = 1'b1;
        SW = 10'h000;
        step(10);
        check("frozen_hold", HOLD, 1);
        check("frozen_x", X, 4'h5);
        check("frozen_y", Y, 4'hA);
        check("frozen_op", OPERATION, 2'd2);
        KEY[1] = 1'b0;
        step(7);
        check("unhold", HOLD, 0);
        step(3);
        check("unhold_x", X, 0);
        check("unhold_y", Y, 0);
        check("unhold_op", OPERATION, 0);
        KEY[1] = 1'b1;
        step(10);

        // Simultaneous: first bring MODE to 1
        KEY[0] = 1'b0;
        step(10);
        KEY[0] = 1'b1;
        step(10);
        check("sim_setup", MODE, 1);
        KEY = 2'b00;
        step(6);
        check("sim_pre_mode", MODE, 1);
        check("sim_pre_hold", HOLD, 0);
        step(1);
        check("sim_mode", MODE, 2);
        check("sim_hold", HOLD, 1);
        check("sim_mc", MODE_CHANGE, 1);
        step(3);
        KEY = 2'b11;
        step(10);

        // Held KEY[0] for 60 cycles
        KEY[0] = 1'b0;
        count_mc(60, pulses);
        KEY[0] = 1'b1;
        begin
            int tail;
            count_mc(10, tail);
            pulses += tail;
        end
`ifdef MODE_CONTROLLER_AUTO_SCAN_EN
        check("scan_pulses", pulses, 4);
        check("scan_mode", MODE, 2'd2);
`else
        check("scan_pulses", pulses, 1);
        check("scan_mode", MODE, 2'd3);
`endif

        // Reset mid-operation with KEY[0] held through reset
        KEY[0] = 1'b0;
        step(2);
        RST = 1'b1;
        step(2);
        check("midrst_mode", MODE, 0);
        check("midrst_hold", HOLD, 0);
        RST = 1'b0;
        count_mc(20, pulses);
        check("held_mc", pulses, 0);
        check("held_mode", MODE, 0);
        KEY[0] = 1'b1;
        step(10);
        KEY[0] = 1'b0;
        step(7);
        check("repress_mode", MODE, 1);
        KEY[0] = 1'b1;
        step(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
